scan_sequencer: RTL and testbench

Frame-level scan controller for the pressure-matrix front end. Steps the column/row demultiplexers and waits a settling time per cell. Triggers one ADC conversion per cell and streams the result as a framed byte sequence to the UART transmitter over a valid/ready handshake. Runs entirely on the system clock.

---
 rtl/scan_sequencer_if.sv | 27 ++
 rtl/scan_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_scan_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_sequencer_if.sv
// Byte stream from the scan sequencer to the UART transmitter.
// The master offers tx_data with tx_valid and the frame-marker flags; the
// slave accepts with tx_ready. A byte moves on a rising edge where both
// tx_valid and tx_ready are high.
interface scan_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       HEAD_UART;
    logic       TAIL_UART;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        output HEAD_UART,
        output TAIL_UART
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        input  HEAD_UART,
        input  TAIL_UART
    );
endinterface

// File: rtl/scan_sequencer.sv
// Frame-level scan controller for the pressure-matrix front end.
// Walks every cell of the DIMX x DIMY matrix (X inner, Y outer), waits SETTLE
// cycles after each address change, triggers one ADC conversion and streams
// the top 8 bits of each result to the UART as HEAD, data..., TAIL.
// Optional feature macro: SCAN_CHECKSUM_EN adds an XOR checksum byte before
// the tail. The default build (macro undefined) sends no checksum.
// Reset is synchronous and active-low; every output is registered.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | addresses at 0, nothing offered, waiting for config_done
// ST_HEAD    | offering HEAD_BYTE with HEAD_UART high, checksum cleared
// ST_SETTLE  | address held stable, settle counter running down
// ST_START   | adc_start high for this single cycle
// ST_CONVERT | waiting for adc_done or the conversion timeout
// ST_SEND    | offering the latched, clamped data byte
// ST_ADVANCE | step X (inner) / Y (outer) or finish the frame
// ST_CSUM    | offering the clamped XOR checksum (SCAN_CHECKSUM_EN only)
// ST_TAIL    | offering TAIL_BYTE with TAIL_UART high
module scan_sequencer #(
    parameter int unsigned DIMX        = 31,
    parameter int unsigned DIMY        = 128,
    parameter int unsigned SETTLE      = 16,
    parameter int unsigned ADC_TIMEOUT = 255,
    parameter logic [7:0]  HEAD_BYTE   = 8'hFF,
    parameter logic [7:0]  TAIL_BYTE   = 8'hFE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             config_done,
    output logic [4:0]       deMUX_X,
    output logic [8:0]       deMUX_Y,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [11:0]      adc_data,
    output logic             frame_active,
    output logic             adc_err,
    scan_sequencer_if.master tx
);

    // Elaboration-time parameter range guards.
    if (DIMX < 1 || DIMX > 32) begin : g_bad_dimx
        $error("scan_sequencer: DIMX must be in 1..32");
    end
    if (DIMY < 1 || DIMY > 512) begin : g_bad_dimy
        $error("scan_sequencer: DIMY must be in 1..512");
    end
    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("scan_sequencer: SETTLE must be in 1..255");
    end
    if (ADC_TIMEOUT > 255) begin : g_bad_timeout
        $error("scan_sequencer: ADC_TIMEOUT must be at most 255");
    end

    localparam logic [4:0] X_LAST     = 5'(DIMX - 1);
    localparam logic [8:0] Y_LAST     = 9'(DIMY - 1);
    localparam logic [7:0] SETTLE_LD  = 8'(SETTLE);
    localparam logic [7:0] TIMEOUT_LD = 8'(ADC_TIMEOUT);
    // Data and checksum bytes must never alias the frame markers.
    localparam logic [7:0] CLAMP_MAX  = 8'hFD;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HEAD,
        ST_SETTLE,
        ST_START,
        ST_CONVERT,
        ST_SEND,
        ST_ADVANCE,
`ifdef SCAN_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_TAIL
    } state_t;

    function automatic logic [7:0] clamp_byte(input logic [7:0] b);
        return (b >= 8'hFE) ? CLAMP_MAX : b;
    endfunction

    state_t     state_q;
    logic [4:0] x_q;
    logic [8:0] y_q;
    logic [7:0] settle_cnt_q;
    logic [7:0] tmo_cnt_q;
    logic       adc_start_q;
    logic [7:0] tx_data_q;
    logic       tx_valid_q;
    logic       head_q;
    logic       tail_q;
    logic       frame_active_q;
    logic       adc_err_q;
`ifdef SCAN_CHECKSUM_EN
    logic [7:0] csum_q;
`endif

    // Only the top 8 bits of a conversion are streamed.
    logic unused_adc_lsbs;
    assign unused_adc_lsbs = ^adc_data[3:0];

    logic [7:0] adc_byte;
    assign adc_byte = clamp_byte(adc_data[11:4]);

    // Scan FSM: state, addresses, timers and all registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            x_q            <= '0;
            y_q            <= '0;
            settle_cnt_q   <= '0;
            tmo_cnt_q      <= '0;
            adc_start_q    <= 1'b0;
            tx_data_q      <= '0;
            tx_valid_q     <= 1'b0;
            head_q         <= 1'b0;
            tail_q         <= 1'b0;
            frame_active_q <= 1'b0;
            adc_err_q      <= 1'b0;
`ifdef SCAN_CHECKSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (config_done) begin
                        state_q        <= ST_HEAD;
                        tx_data_q      <= HEAD_BYTE;
                        tx_valid_q     <= 1'b1;
                        head_q         <= 1'b1;
                        frame_active_q <= 1'b1;
                    end
                end

                ST_HEAD: begin
`ifdef SCAN_CHECKSUM_EN
                    csum_q <= '0;
`endif
                    if (tx.tx_ready) begin
                        tx_valid_q   <= 1'b0;
                        head_q       <= 1'b0;
                        settle_cnt_q <= SETTLE_LD;
                        state_q      <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    // Leaving on the count that reaches zero gives exactly
                    // SETTLE cycles of stable address before adc_start.
                    if (settle_cnt_q <= 8'd1) begin
                        settle_cnt_q <= '0;
                        adc_start_q  <= 1'b1;
                        state_q      <= ST_START;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 8'd1;
                    end
                end

                ST_START: begin
                    adc_start_q <= 1'b0;
                    tmo_cnt_q   <= TIMEOUT_LD;
                    state_q     <= ST_CONVERT;
                end

                ST_CONVERT: begin
                    if (adc_done) begin
                        tx_data_q  <= adc_byte;
                        tx_valid_q <= 1'b1;
                        tmo_cnt_q  <= '0;
                        state_q    <= ST_SEND;
`ifdef SCAN_CHECKSUM_EN
                        csum_q     <= csum_q ^ adc_byte;
`endif
                    end else if (tmo_cnt_q <= 8'd1) begin
                        // Substitute zero so the frame keeps its length;
                        // zero leaves the checksum unchanged.
                        tx_data_q  <= 8'h00;
                        tx_valid_q <= 1'b1;
                        adc_err_q  <= 1'b1;
                        tmo_cnt_q  <= '0;
                        state_q    <= ST_SEND;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q - 8'd1;
                    end
                end

                ST_SEND: begin
                    if (tx.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= ST_ADVANCE;
                    end
                end

                ST_ADVANCE: begin
                    if (x_q < X_LAST) begin
                        x_q          <= x_q + 5'd1;
                        settle_cnt_q <= SETTLE_LD;
                        state_q      <= ST_SETTLE;
                    end else if (y_q < Y_LAST) begin
                        x_q          <= '0;
                        y_q          <= y_q + 9'd1;
                        settle_cnt_q <= SETTLE_LD;
                        state_q      <= ST_SETTLE;
                    end else begin
                        // Return to (0,0) here so the address only ever
                        // moves on the edge leaving this state.
                        x_q        <= '0;
                        y_q        <= '0;
                        tx_valid_q <= 1'b1;
`ifdef SCAN_CHECKSUM_EN
                        tx_data_q  <= clamp_byte(csum_q);
                        state_q    <= ST_CSUM;
`else
                        tx_data_q  <= TAIL_BYTE;
                        tail_q     <= 1'b1;
                        state_q    <= ST_TAIL;
`endif
                    end
                end

`ifdef SCAN_CHECKSUM_EN
                ST_CSUM: begin
                    if (tx.tx_ready) begin
                        tx_data_q <= TAIL_BYTE;
                        tail_q    <= 1'b1;
                        state_q   <= ST_TAIL;
                    end
                end
`endif

                ST_TAIL: begin
                    if (tx.tx_ready) begin
                        tail_q <= 1'b0;
                        if (config_done) begin
                            // Back-to-back frame: header follows at once.
                            tx_data_q <= HEAD_BYTE;
                            head_q    <= 1'b1;
                            state_q   <= ST_HEAD;
                        end else begin
                            tx_valid_q     <= 1'b0;
                            frame_active_q <= 1'b0;
                            state_q        <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign deMUX_X      = x_q;
    assign deMUX_Y      = y_q;
    assign adc_start    = adc_start_q;
    assign frame_active = frame_active_q;
    assign adc_err      = adc_err_q;

    assign tx.tx_data   = tx_data_q;
    assign tx.tx_valid  = tx_valid_q;
    assign tx.HEAD_UART = head_q;
    assign tx.TAIL_UART = tail_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer on a 2x2 matrix, SETTLE=3, ADC answering 4 cycles
// after adc_start. Expected frames come from a cell-table model and are
// queued as stimulus is issued; a monitor pops them as bytes are accepted.
module tb_scan_sequencer;

    typedef struct packed {
        logic [7:0] data;
        logic       head;
        logic       tail;
    } exp_t;

`ifdef SCAN_CHECKSUM_EN
    localparam int FRAME_LEN = 42;
`else
    localparam int FRAME_LEN = 41;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        config_done = 1'b0;
    logic [4:0]  deMUX_X;
    logic [8:0]  deMUX_Y;
    logic        adc_start;
    logic        adc_done = 1'b0;
    logic [11:0] adc_data = '0;
    logic        frame_active;
    logic        adc_err;

    scan_sequencer_if tx_if();

    always #5 clock = ~clock;

    scan_sequencer #(
        .DIMX(2), .DIMY(2), .SETTLE(3), .ADC_TIMEOUT(255)
    ) dut (
        .clock(clock),
        .reset(reset),
        .config_done(config_done),
        .deMUX_X(deMUX_X),
        .deMUX_Y(deMUX_Y),
        .adc_start(adc_start),
        .adc_done(adc_done),
        .adc_data(adc_data),
        .frame_active(frame_active),
        .adc_err(adc_err),
        .tx(tx_if)
    );

    int errors = 0;
    int checks = 0;

    logic [11:0] adc_val[4];
    bit          noresp[4];
    exp_t        exp_q[$];
    int          addr_q[$];
    bit          rnd_ready = 0;
    bit          len_chk = 0;
    bit          expect_b2b = 0;
    bit          stray_req = 0;
    int          heads = 0;
    int          tails = 0;
    int          cur_idx;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference frame: header, one byte per cell in X-inner order, optional
    // checksum, tail. Also queues the cell order expected at each adc_start.
    task automatic push_frame();
        logic [7:0] b;
        logic [7:0] cs;
        int v;
        cs = 8'h00;
        exp_q.push_back('{8'hFF, 1'b1, 1'b0});
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 2; x++) begin
                if (noresp[y*2+x]) b = 8'h00;
                else begin
                    v = int'(adc_val[y*2+x]) / 16;
                    b = (v >= 254) ? 8'hFD : 8'(v);
                end
                cs = cs ^ b;
                exp_q.push_back('{b, 1'b0, 1'b0});
                addr_q.push_back(y*2+x);
            end
        end
`ifdef SCAN_CHECKSUM_EN
        exp_q.push_back('{((cs >= 8'hFE) ? 8'hFD : cs), 1'b0, 1'b0});
`endif
        exp_q.push_back('{8'hFE, 1'b0, 1'b1});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"},            int'(deMUX_X), 0);
        check({tag, "_y"},            int'(deMUX_Y), 0);
        check({tag, "_adc_start"},    int'(adc_start), 0);
        check({tag, "_tx_data"},      int'(tx_if.tx_data), 0);
        check({tag, "_tx_valid"},     int'(tx_if.tx_valid), 0);
        check({tag, "_head"},         int'(tx_if.HEAD_UART), 0);
        check({tag, "_tail"},         int'(tx_if.TAIL_UART), 0);
        check({tag, "_frame_active"}, int'(frame_active), 0);
        check({tag, "_adc_err"},      int'(adc_err), 0);
    endtask

    task automatic wait_heads(input int target, input int budget);
        int n = 0;
        while (heads < target && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        check("wait_head_accept", int'(heads >= target), 1);
    endtask

    task automatic wait_tails(input int target, input int budget);
        int n = 0;
        while (tails < target && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        check("wait_tail_accept", int'(tails >= target), 1);
    endtask

    // Driver and timing observer, 1 time unit after each rising edge:
    // tx_ready, ADC model, settle gap, cell order and conversion latency.
    initial begin
        int cd = 0;
        int pend = -1;
        int tick = 0;
        int start_tick = 0;
        int ref_tick = 0;
        logic [4:0] px = '0;
        logic [8:0] py = '0;
        logic ph = 1'b0, pv = 1'b0, ps = 1'b0;
        int e;
        tx_if.tx_ready = 1'b1;
        forever begin
            @(posedge clock); #1;
            tick++;
            tx_if.tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            adc_done = 1'b0;
            adc_data = 12'($urandom_range(0, 4095));
            if (!reset) begin
                cd = 0;
                pend = -1;
            end else if (stray_req) begin
                adc_done = 1'b1;
                adc_data = 12'hFF0;
                stray_req = 0;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    cur_idx = int'(deMUX_X) + 2 * int'(deMUX_Y);
                    if (!noresp[cur_idx]) begin
                        adc_done = 1'b1;
                        adc_data = adc_val[cur_idx];
                    end
                end
            end

            if (deMUX_X != px || deMUX_Y != py || (ph && !tx_if.HEAD_UART))
                ref_tick = tick;

            if (reset && adc_start) begin
                check("adc_start_one_cycle", int'(ps), 0);
                if (!ps) begin
                    cd = 4;
                    check("settle_cycles", tick - ref_tick, 3);
                    check("cell_expected", int'(addr_q.size() > 0), 1);
                    if (addr_q.size() > 0) begin
                        e = addr_q.pop_front();
                        check("cell_x", int'(deMUX_X), e % 2);
                        check("cell_y", int'(deMUX_Y), e / 2);
                    end
                    start_tick = tick;
                    pend = int'(deMUX_X) + 2 * int'(deMUX_Y);
                end
            end

            if (reset && tx_if.tx_valid && !pv && pend >= 0) begin
                check("convert_latency", tick - start_tick, noresp[pend] ? 256 : 5);
                pend = -1;
            end

            px = deMUX_X;
            py = deMUX_Y;
            ph = tx_if.HEAD_UART;
            pv = tx_if.tx_valid;
            ps = adc_start;
        end
    end

    // Monitor on the falling edge: pops the scoreboard on each accepted byte
    // and checks the handshake hold rule and marker alignment.
    initial begin
        logic hold = 1'b0;
        logic [7:0] hold_data = '0;
        logic hprev = 1'b0;
        logic b2b_pend = 1'b0;
        int ncyc = 0;
        int head_cyc = 0;
        exp_t e;
        forever begin
            @(negedge clock);
            ncyc++;
            if (!reset) begin
                hold = 1'b0;
                hprev = 1'b0;
                b2b_pend = 1'b0;
            end else begin
                if (b2b_pend) begin
                    check("b2b_head_offered", int'(tx_if.tx_valid && tx_if.HEAD_UART), 1);
                    b2b_pend = 1'b0;
                end
                if (hold) begin
                    check("hold_valid", int'(tx_if.tx_valid), 1);
                    check("hold_data", int'(tx_if.tx_data), int'(hold_data));
                end
                if (tx_if.tx_valid)
                    check("frame_active_during_offer", int'(frame_active), 1);
                if (tx_if.tx_valid && tx_if.HEAD_UART && !hprev)
                    head_cyc = ncyc;
                if (tx_if.tx_valid && tx_if.tx_ready) begin
                    check("byte_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("tx_data", int'(tx_if.tx_data), int'(e.data));
                        check("head_flag", int'(tx_if.HEAD_UART), int'(e.head));
                        check("tail_flag", int'(tx_if.TAIL_UART), int'(e.tail));
                    end
                    if (tx_if.HEAD_UART) begin
                        heads++;
                        check("head_at_origin", int'({deMUX_Y, deMUX_X}), 0);
                    end
                    if (tx_if.TAIL_UART) begin
                        tails++;
                        if (len_chk) check("frame_length", ncyc - head_cyc, FRAME_LEN);
                        if (expect_b2b) b2b_pend = 1'b1;
                    end
                end
                hold = tx_if.tx_valid && !tx_if.tx_ready;
                hold_data = tx_if.tx_data;
                hprev = tx_if.tx_valid && tx_if.HEAD_UART;
            end
        end
    end

    initial begin
        #500000;
        errors++;
        checks++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int h0, t0, n;
        for (int i = 0; i < 4; i++) noresp[i] = 0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("idle_no_offer", int'(tx_if.tx_valid), 0);

        // Frame A: known values, ready tied high, config_done dropped after header.
        adc_val[0] = 12'h120; adc_val[1] = 12'h340;
        adc_val[2] = 12'h560; adc_val[3] = 12'h780;
        push_frame();
        len_chk = 1;
        @(posedge clock); #1;
        config_done = 1'b1;
        wait_heads(1, 50);
        config_done = 1'b0;
        wait_tails(1, 200);
        len_chk = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("a_idle_frame_active", int'(frame_active), 0);
        check("a_idle_valid", int'(tx_if.tx_valid), 0);
        check("a_adc_err", int'(adc_err), 0);
        check("a_bytes_left", exp_q.size(), 0);
        check("a_cells_left", addr_q.size(), 0);

        // Stray ADC pulse while idle must not start anything.
        stray_req = 1;
        repeat (20) @(posedge clock);
        @(negedge clock);
        check("stray_no_head", heads, 1);
        check("stray_idle_valid", int'(tx_if.tx_valid), 0);

        // Frames B and C back to back: clamp, unclamped, timeout cell, random ready.
        adc_val[0] = 12'hFF3; adc_val[1] = 12'h555;
        adc_val[2] = 12'hABC; adc_val[3] = 12'($urandom_range(0, 4095));
        noresp[1] = 1;
        push_frame();
        push_frame();
        h0 = heads; t0 = tails;
        rnd_ready = 1;
        expect_b2b = 1;
        @(posedge clock); #1;
        config_done = 1'b1;
        wait_heads(h0 + 2, 3000);
        expect_b2b = 0;
        config_done = 1'b0;
        check("bc_err_set", int'(adc_err), 1);
        wait_tails(t0 + 2, 3000);
        rnd_ready = 0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("bc_err_sticky", int'(adc_err), 1);
        check("bc_idle_frame_active", int'(frame_active), 0);
        check("bc_bytes_left", exp_q.size(), 0);
        noresp[1] = 0;

        // Frame D: random values, reset during CONVERT of cell (1,1).
        for (int i = 0; i < 4; i++) adc_val[i] = 12'($urandom_range(0, 4095));
        push_frame();
        rnd_ready = 1;
        @(posedge clock); #1;
        config_done = 1'b1;
        n = 0;
        while (!(adc_start && deMUX_X == 5'd1 && deMUX_Y == 9'd1) && n < 2000) begin
            @(posedge clock); #1;
            n++;
        end
        check("d_reached_cell_11", int'(adc_start && deMUX_X == 5'd1 && deMUX_Y == 9'd1), 1);
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        addr_q.delete();
        @(posedge clock);
        @(negedge clock);
        check_all_zero("midreset");
        rnd_ready = 0;

        // Frame E after release: fresh frame from (0,0), then idle.
        for (int i = 0; i < 4; i++) adc_val[i] = 12'($urandom_range(0, 4095));
        push_frame();
        len_chk = 1;
        h0 = heads; t0 = tails;
        @(posedge clock); #1;
        reset = 1'b1;
        wait_heads(h0 + 1, 50);
        config_done = 1'b0;
        wait_tails(t0 + 1, 200);
        len_chk = 0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("e_idle_frame_active", int'(frame_active), 0);
        check("e_adc_err", int'(adc_err), 0);
        check("e_bytes_left", exp_q.size(), 0);
        check("e_cells_left", addr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
